// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline stage register.
// The occupancy encoding equals the number of held entries.
package pipe_pkg;

   localparam int DEF_CTRL_W = 16;
   localparam int DEF_DATA_W = 64;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occ_state_t;

endpackage : pipe_pkg

// File: rtl/pipe_stage_entry.sv
// One ctrl+data storage slot of the pipeline stage.
// The slot loads on i_load and clears only on reset.
module pipe_stage_entry
   import pipe_pkg::*;
#(
   parameter int CTRL_W = DEF_CTRL_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_load,
   input  logic [CTRL_W-1:0] i_ctrl,
   input  logic [DATA_W-1:0] i_data,
   output logic [CTRL_W-1:0] o_ctrl,
   output logic [DATA_W-1:0] o_data
);

   logic [CTRL_W-1:0] r_ctrl;
   logic [DATA_W-1:0] r_data;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_ctrl <= '0;
         r_data <= '0;
      end else if (i_load) begin
         r_ctrl <= i_ctrl;
         r_data <= i_data;
      end
   end

   assign o_ctrl = r_ctrl;
   assign o_data = r_data;

endmodule : pipe_stage_entry

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage: single register by default, or a 2-entry
// skid buffer with registered up_ready when PIPE_STAGE_SKID_EN is defined.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int                CTRL_W   = DEF_CTRL_W,
   parameter int                DATA_W   = DEF_DATA_W,
   parameter logic [CTRL_W-1:0] CLR_MASK = {CTRL_W{1'b1}}
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              up_valid,
   output logic              up_ready,
   input  logic [CTRL_W-1:0] up_ctrl,
   input  logic [DATA_W-1:0] up_data,
   output logic              down_valid,
   input  logic              down_ready,
   output logic [CTRL_W-1:0] down_ctrl,
   output logic [DATA_W-1:0] down_data,
   output logic [1:0]        occ
);

`ifdef PIPE_STAGE_SKID_EN
   localparam int NUM_ENT = 2;
`else
   localparam int NUM_ENT = 1;
`endif

   occ_state_t r_state;
   occ_state_t w_state_next;

   logic [NUM_ENT-1:0] w_load;
   logic [CTRL_W-1:0]  w_ld_ctrl  [NUM_ENT];
   logic [DATA_W-1:0]  w_ld_data  [NUM_ENT];
   logic [CTRL_W-1:0]  w_ent_ctrl [NUM_ENT];
   logic [DATA_W-1:0]  w_ent_data [NUM_ENT];

   logic w_down_valid;
   logic w_up_ready;
   logic w_accept;
   logic w_deliver;

   assign w_down_valid = (r_state != EMPTY);

`ifdef PIPE_STAGE_SKID_EN
   // Depends only on stored occupancy, so no path from down_ready.
   assign w_up_ready = !reset && (r_state != FULL);
`else
   assign w_up_ready = !reset && (!w_down_valid || down_ready);
`endif

   assign w_accept  = up_valid && w_up_ready;
   assign w_deliver = w_down_valid && down_ready;

   always_comb begin
      w_state_next = r_state;
      w_load       = '0;
      for (int i = 0; i < NUM_ENT; i++) begin
         w_ld_ctrl[i] = up_ctrl;
         w_ld_data[i] = up_data;
      end
      // Flush drops the incoming beat and leaves stored values in place.
      if (flush) begin
         w_state_next = EMPTY;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_accept) begin
                  w_load[0]    = 1'b1;
                  w_state_next = ONE;
               end
            end
            ONE: begin
`ifdef PIPE_STAGE_SKID_EN
               if (w_accept && w_deliver) begin
                  w_load[0] = 1'b1;
               end else if (w_accept) begin
                  w_load[1]    = 1'b1;
                  w_state_next = FULL;
               end else if (w_deliver) begin
                  w_state_next = EMPTY;
               end
`else
               if (w_accept) begin
                  w_load[0] = 1'b1;
               end else if (w_deliver) begin
                  w_state_next = EMPTY;
               end
`endif
            end
`ifdef PIPE_STAGE_SKID_EN
            FULL: begin
               // Skid slot moves to head; up_ready is low so nothing enters.
               if (w_deliver) begin
                  w_load[0]    = 1'b1;
                  w_ld_ctrl[0] = w_ent_ctrl[1];
                  w_ld_data[0] = w_ent_data[1];
                  w_state_next = ONE;
               end
            end
`endif
            default: w_state_next = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_state_next;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_ENT; gi++) begin : g_entry
         pipe_stage_entry #(
            .CTRL_W (CTRL_W),
            .DATA_W (DATA_W)
         ) u_entry (
            .clock  (clock),
            .reset  (reset),
            .i_load (w_load[gi]),
            .i_ctrl (w_ld_ctrl[gi]),
            .i_data (w_ld_data[gi]),
            .o_ctrl (w_ent_ctrl[gi]),
            .o_data (w_ent_data[gi])
         );
      end
   endgenerate

   assign up_ready   = w_up_ready;
   assign down_valid = w_down_valid;
   assign down_ctrl  = w_down_valid ? w_ent_ctrl[0] : (w_ent_ctrl[0] & ~CLR_MASK);
   assign down_data  = w_ent_data[0];
   assign occ        = r_state;

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// Directed plus random bench for pipe_stage_reg with a queue scoreboard.
// Works for both the single-entry and PIPE_STAGE_SKID_EN builds.
module tb_pipe_stage_reg;

   localparam int                CTRL_W   = 16;
   localparam int                DATA_W   = 64;
   localparam logic [CTRL_W-1:0] CLR_MASK = 16'h00FF;
`ifdef PIPE_STAGE_SKID_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] data;
   } beat_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              flush = 1'b0;
   logic              up_valid = 1'b0;
   logic              up_ready;
   logic [CTRL_W-1:0] up_ctrl = '0;
   logic [DATA_W-1:0] up_data = '0;
   logic              down_valid;
   logic              down_ready = 1'b0;
   logic [CTRL_W-1:0] down_ctrl;
   logic [DATA_W-1:0] down_data;
   logic [1:0]        occ;

   beat_t sb[$];
   beat_t head = '0;
   bit    model_ok = 1'b0;
   int    n_checks = 0;
   int    n_errors = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(
      .CTRL_W   (CTRL_W),
      .DATA_W   (DATA_W),
      .CLR_MASK (CLR_MASK)
   ) dut (
      .clock      (clk),
      .reset      (reset),
      .flush      (flush),
      .up_valid   (up_valid),
      .up_ready   (up_ready),
      .up_ctrl    (up_ctrl),
      .up_data    (up_data),
      .down_valid (down_valid),
      .down_ready (down_ready),
      .down_ctrl  (down_ctrl),
      .down_data  (down_data),
      .occ        (occ)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive at negedge, check against the model, update at posedge.
   task automatic cycle(input logic rst, input logic fl, input logic uv,
                        input logic [CTRL_W-1:0] uc, input logic [DATA_W-1:0] ud,
                        input logic dr);
      logic  exp_ur;
      logic  exp_dv;
      beat_t item;
      reset = rst; flush = fl; up_valid = uv; up_ctrl = uc; up_data = ud; down_ready = dr;
      #1;
      exp_dv = 1'b0;
      if (rst)           exp_ur = 1'b0;
      else if (CAP == 2) exp_ur = (sb.size() < 2);
      else               exp_ur = (sb.size() == 0) || dr;
      chk("up_ready", 64'(up_ready), 64'(exp_ur));
      if (model_ok) begin
         exp_dv = (sb.size() != 0);
         chk("occ", 64'(occ), 64'(sb.size()));
         chk("down_valid", 64'(down_valid), 64'(exp_dv));
         if (exp_dv) begin
            chk("down_ctrl", 64'(down_ctrl), 64'(sb[0].ctrl));
            chk("down_data", down_data, sb[0].data);
         end else begin
            chk("idle_ctrl", 64'(down_ctrl), 64'(head.ctrl & ~CLR_MASK));
            chk("idle_data", down_data, head.data);
         end
      end
      @(posedge clk);
      if (rst) begin
         sb.delete();
         head = '0;
         model_ok = 1'b1;
         $display("reset%s", fl ? " with flush" : "");
      end else if (model_ok) begin
         if (exp_dv && dr) begin
            item = sb.pop_front();
            $display("deliver ctrl=%h data=%h", item.ctrl, item.data);
         end
         if (fl) begin
            sb.delete();
            $display("flush");
         end else if (uv && exp_ur) begin
            item.ctrl = uc;
            item.data = ud;
            sb.push_back(item);
            $display("accept  ctrl=%h data=%h", uc, ud);
         end
         if (sb.size() != 0) head = sb[0];
      end
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      // Reset, then an idle cycle checks the post-reset state.
      cycle(1, 0, 0, '0, '0, 0);
      cycle(1, 0, 1, 16'h1111, 64'h99, 1);
      cycle(0, 0, 0, '0, '0, 0);
      chk("rst_down_data", down_data, 64'h0);

      // Stream 1..8 at full rate.
      for (int i = 1; i <= 8; i++)
         cycle(0, 0, 1, 16'h1000 + 16'(i), 64'(i), 1);
      cycle(0, 0, 0, '0, '0, 1);
      cycle(0, 0, 0, '0, '0, 1);

      // Stall: push A, B, C with down_ready low, then release.
      cycle(0, 0, 1, 16'h0A0A, 64'hA, 0);
      cycle(0, 0, 1, 16'h0B0B, 64'hB, 0);
      cycle(0, 0, 1, 16'h0C0C, 64'hC, 0);
      chk("stall_occ", 64'(occ), 64'(CAP));
      for (int i = 0; i < 3; i++)
         cycle(0, 0, 0, '0, '0, 1);

      // Same-cycle accept and deliver at one entry.
      cycle(0, 0, 1, 16'h0005, 64'h5, 0);
      cycle(0, 0, 1, 16'h0006, 64'h6, 1);
      chk("swap_occ", 64'(occ), 64'd1);
      chk("swap_data", down_data, 64'h6);
      cycle(0, 0, 0, '0, '0, 1);

      // Flush while holding ctrl ABCD; the incoming beat is discarded.
      cycle(0, 0, 1, 16'hABCD, 64'h1234, 0);
      cycle(0, 1, 1, 16'hFFFF, 64'hDEAD, 0);
      chk("flush_valid", 64'(down_valid), 64'd0);
      chk("flush_ctrl", 64'(down_ctrl), 64'h0000_0000_0000_AB00);
      chk("flush_data", down_data, 64'h1234);
      cycle(0, 0, 0, '0, '0, 1);

      // Reset and flush together while occupied.
      cycle(0, 0, 1, 16'h7171, 64'h71, 0);
      cycle(0, 0, 1, 16'h7272, 64'h72, 0);
      cycle(1, 1, 1, 16'h7373, 64'h73, 1);
      chk("rstfl_occ", 64'(occ), 64'd0);
      chk("rstfl_ctrl", 64'(down_ctrl), 64'd0);
      chk("rstfl_data", down_data, 64'd0);
      cycle(0, 0, 0, '0, '0, 0);

      // Random traffic with occasional flushes.
      for (int i = 0; i < 80; i++)
         cycle(0, ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
               16'($urandom), {$urandom, $urandom}, ($urandom_range(0, 3) != 0));
      for (int i = 0; i < 3; i++)
         cycle(0, 0, 0, '0, '0, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_pipe_stage_reg
